// File: rtl/r200ex_seq.sv
// r200ex_seq -- execute-stage sequencer for the r200 integer execute unit.
//
// Holds one instruction in a stage register and drives the external
// combinational execute unit from it. Decode hands instructions in with
// in_valid/in_ready; results go to writeback with out_valid/out_ready.
// A taken branch or jump raises a one-cycle fetch redirect when it retires.
// After that, incoming wrong-path instructions are accepted and discarded
// for SQUASH_CYC cycles.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   flush                synchronous flush, overrides everything else
//   in_*                 instruction from decode (valid/ready handshake)
//   ex_* (out)           stage-register contents to the execute unit
//   ex_alu_res, ex_pc_jumptarg, ex_willbr (in)   execute-unit results
//   out_valid/out_ready, out_res, out_rd, out_we   writeback handshake
//   redirect_valid, redirect_pc                    fetch redirect
//   perf_retired, perf_redirects                   performance counters
//
// Optional feature: define R200EX_SEQ_PERF_EN to build the two 32-bit
// performance counters. When it is undefined, both ports read 0.
module r200ex_seq #(
  parameter int SQUASH_CYC = 2,
  parameter int TAG_W      = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_op1,
  input  logic [31:0]      in_op2,
  input  logic             in_alu_cont,
  input  logic [2:0]       in_func3,
  input  logic             in_is_branch,
  input  logic             in_is_jump,
  input  logic [31:0]      in_jump_imm,
  input  logic [31:0]      in_jump_addimm,
  input  logic [TAG_W-1:0] in_rd,
  output logic [31:0]      ex_op1,
  output logic [31:0]      ex_op2,
  output logic [31:0]      ex_jump_imm,
  output logic [31:0]      ex_jump_addimm,
  output logic             ex_alu_cont,
  output logic [2:0]       ex_func3,
  input  logic [31:0]      ex_alu_res,
  input  logic [31:0]      ex_pc_jumptarg,
  input  logic             ex_willbr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_res,
  output logic [TAG_W-1:0] out_rd,
  output logic             out_we,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic [31:0]      perf_retired,
  output logic [31:0]      perf_redirects
);

  localparam logic [1:0] S_EMPTY  = 2'd0;
  localparam logic [1:0] S_FULL   = 2'd1;
  localparam logic [1:0] S_SQUASH = 2'd2;
  localparam logic [3:0] SQ_LOAD  = 4'(SQUASH_CYC);

  typedef struct packed {
    logic [31:0]      op1;
    logic [31:0]      op2;
    logic [31:0]      jump_imm;
    logic [31:0]      jump_addimm;
    logic             alu_cont;
    logic [2:0]       func3;
    logic             is_branch;
    logic             is_jump;
    logic [TAG_W-1:0] rd;
  } stage_t;

  logic [1:0] state;
  logic [3:0] sq_cnt;
  stage_t     stg;

  logic full, taken, retire, accept, load;

  assign full   = (state == S_FULL);
  assign taken  = full & (stg.is_jump | (stg.is_branch & ex_willbr));
  assign retire = full & out_ready;

  // A taken instruction blocks new input while it leaves, because whatever
  // decode offers in that cycle is already wrong-path.
  always_comb begin
    in_ready = 1'b0;
    if (!flush) begin
      case (state)
        S_EMPTY:  in_ready = 1'b1;
        S_FULL:   in_ready = out_ready & ~taken;
        S_SQUASH: in_ready = 1'b1;
        default:  in_ready = 1'b0;
      endcase
    end
  end

  assign accept = in_valid & in_ready;
  // Handshakes that complete during SQUASH are consumed but never captured.
  assign load   = accept & (state != S_SQUASH);

  assign out_valid      = full & ~flush;
  assign redirect_valid = retire & taken & ~flush;
  // Result-side data is forced to zero outside FULL, so these outputs are
  // quiet when idle and during reset.
  assign out_res        = full ? ex_alu_res : 32'd0;
  assign redirect_pc    = full ? ex_pc_jumptarg : 32'd0;
  assign out_rd         = full ? stg.rd : '0;
  assign out_we         = full & ~stg.is_branch;

  assign ex_op1         = stg.op1;
  assign ex_op2         = stg.op2;
  assign ex_jump_imm    = stg.jump_imm;
  assign ex_jump_addimm = stg.jump_addimm;
  assign ex_alu_cont    = stg.alu_cont;
  assign ex_func3       = stg.func3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg <= '0;
    end else if (load) begin
      stg.op1         <= in_op1;
      stg.op2         <= in_op2;
      stg.jump_imm    <= in_jump_imm;
      stg.jump_addimm <= in_jump_addimm;
      stg.alu_cont    <= in_alu_cont;
      stg.func3       <= in_func3;
      stg.is_branch   <= in_is_branch;
      stg.is_jump     <= in_is_jump;
      stg.rd          <= in_rd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_EMPTY;
      sq_cnt <= 4'd0;
    end else if (flush) begin
      state  <= S_EMPTY;
      sq_cnt <= 4'd0;
    end else begin
      case (state)
        S_EMPTY: if (accept) state <= S_FULL;
        S_FULL: begin
          if (retire) begin
            if (taken) begin
              // With SQUASH_CYC = 0, no wrong-path capture is possible,
              // because in_ready was low in the redirect cycle.
              state  <= (SQ_LOAD == 4'd0) ? S_EMPTY : S_SQUASH;
              sq_cnt <= SQ_LOAD;
            end else begin
              state <= accept ? S_FULL : S_EMPTY;
            end
          end
        end
        S_SQUASH: begin
          if (sq_cnt <= 4'd1) begin
            state  <= S_EMPTY;
            sq_cnt <= 4'd0;
          end else begin
            sq_cnt <= sq_cnt - 4'd1;
          end
        end
        default: state <= S_EMPTY;
      endcase
    end
  end

`ifdef R200EX_SEQ_PERF_EN
  // These counters see every retire and redirect. A flush never clears
  // them; only reset does.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_retired   <= 32'd0;
      perf_redirects <= 32'd0;
    end else begin
      if (retire && !flush) perf_retired   <= perf_retired + 32'd1;
      if (redirect_valid)   perf_redirects <= perf_redirects + 32'd1;
    end
  end
`else
  assign perf_retired   = 32'd0;
  assign perf_redirects = 32'd0;
`endif

endmodule

// File: tb/tb_r200ex_seq.sv
// Directed bench for r200ex_seq. A small model of the execute unit supplies
// add/sub results, BEQ/BNE conditions and target = jump_addimm + jump_imm.
module tb_r200ex_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_op1 = '0, in_op2 = '0, in_jump_imm = '0, in_jump_addimm = '0;
  logic        in_alu_cont = 1'b0;
  logic [2:0]  in_func3 = '0;
  logic        in_is_branch = 1'b0, in_is_jump = 1'b0;
  logic [4:0]  in_rd = '0;
  logic [31:0] ex_op1, ex_op2, ex_jump_imm, ex_jump_addimm;
  logic        ex_alu_cont;
  logic [2:0]  ex_func3;
  logic [31:0] ex_alu_res, ex_pc_jumptarg;
  logic        ex_willbr;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_res;
  logic [4:0]  out_rd;
  logic        out_we;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] perf_retired, perf_redirects;

  int n_chk = 0;
  int n_err = 0;

  r200ex_seq #(.SQUASH_CYC(2), .TAG_W(5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op1(in_op1), .in_op2(in_op2), .in_alu_cont(in_alu_cont),
    .in_func3(in_func3), .in_is_branch(in_is_branch), .in_is_jump(in_is_jump),
    .in_jump_imm(in_jump_imm), .in_jump_addimm(in_jump_addimm), .in_rd(in_rd),
    .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_jump_imm(ex_jump_imm),
    .ex_jump_addimm(ex_jump_addimm), .ex_alu_cont(ex_alu_cont), .ex_func3(ex_func3),
    .ex_alu_res(ex_alu_res), .ex_pc_jumptarg(ex_pc_jumptarg), .ex_willbr(ex_willbr),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
    .out_rd(out_rd), .out_we(out_we),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .perf_retired(perf_retired), .perf_redirects(perf_redirects)
  );

  // execute-unit model
  assign ex_alu_res     = ex_alu_cont ? ex_op1 - ex_op2 : ex_op1 + ex_op2;
  assign ex_willbr      = (ex_func3 == 3'b001) ? (ex_op1 != ex_op2) : (ex_op1 == ex_op2);
  assign ex_pc_jumptarg = ex_jump_addimm + ex_jump_imm;

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic [31:0] a, input logic [31:0] b, input logic cont,
                     input logic [2:0] f3, input logic br, input logic jmp,
                     input logic [31:0] imm, input logic [31:0] addimm, input logic [4:0] rd);
    in_valid = 1'b1; in_op1 = a; in_op2 = b; in_alu_cont = cont; in_func3 = f3;
    in_is_branch = br; in_is_jump = jmp; in_jump_imm = imm; in_jump_addimm = addimm;
    in_rd = rd;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  initial begin
    // reset state
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_redirect", 32'(redirect_valid), 32'd0);
    chk("rst_out_res", out_res, 32'd0);
    chk("rst_out_we", 32'(out_we), 32'd0);
    chk("rst_ex_op1", ex_op1, 32'd0);
    chk("rst_perf", perf_retired, 32'd0);
    #12 rst = 1'b0;
    tick();

    // back-to-back ADD then SUB
    out_ready = 1'b1;
    drv(32'd5, 32'd7, 1'b0, 3'b000, 1'b0, 1'b0, 32'd0, 32'd0, 5'd1);
    #1 chk("b2b_ready0", 32'(in_ready), 32'd1);
    tick();
    drv(32'd3, 32'd9, 1'b1, 3'b000, 1'b0, 1'b0, 32'd0, 32'd0, 5'd2);
    #1;
    chk("b2b_v1", 32'(out_valid), 32'd1);
    chk("b2b_res1", out_res, 32'd12);
    chk("b2b_rd1", 32'(out_rd), 32'd1);
    chk("b2b_we1", 32'(out_we), 32'd1);
    chk("b2b_ready1", 32'(in_ready), 32'd1);
    chk("b2b_redir1", 32'(redirect_valid), 32'd0);
    tick();
    idle();
    #1;
    chk("b2b_v2", 32'(out_valid), 32'd1);
    chk("b2b_res2", out_res, 32'hFFFF_FFFA);
    chk("b2b_redir2", 32'(redirect_valid), 32'd0);
    tick();
    chk("b2b_empty", 32'(out_valid), 32'd0);

    // taken BEQ, target 0x100, followed by ADD on the wrong path
    drv(32'd4, 32'd4, 1'b0, 3'b000, 1'b1, 1'b0, 32'h80, 32'h80, 5'd0);
    tick();
    drv(32'd1, 32'd1, 1'b0, 3'b000, 1'b0, 1'b0, 32'd0, 32'd0, 5'd7);
    #1;
    chk("beq_redir", 32'(redirect_valid), 32'd1);
    chk("beq_pc", redirect_pc, 32'h100);
    chk("beq_we", 32'(out_we), 32'd0);
    chk("beq_ready", 32'(in_ready), 32'd0);
    tick();
    chk("sq1_ready", 32'(in_ready), 32'd1);
    chk("sq1_valid", 32'(out_valid), 32'd0);
    chk("sq1_redir", 32'(redirect_valid), 32'd0);
    tick();
    chk("sq2_ready", 32'(in_ready), 32'd1);
    chk("sq2_valid", 32'(out_valid), 32'd0);
    tick();
    // EMPTY: not-taken BNE, then ADD with no bubble
    drv(32'd6, 32'd6, 1'b0, 3'b001, 1'b1, 1'b0, 32'h40, 32'h40, 5'd3);
    #1 chk("empty_valid", 32'(out_valid), 32'd0);
    tick();
    drv(32'd2, 32'd3, 1'b0, 3'b000, 1'b0, 1'b0, 32'd0, 32'd0, 5'd4);
    #1;
    chk("bne_valid", 32'(out_valid), 32'd1);
    chk("bne_redir", 32'(redirect_valid), 32'd0);
    chk("bne_we", 32'(out_we), 32'd0);
    chk("bne_ready", 32'(in_ready), 32'd1);
    tick();
    idle();
    #1;
    chk("bne_next_valid", 32'(out_valid), 32'd1);
    chk("bne_next_res", out_res, 32'd5);
    chk("bne_next_rd", 32'(out_rd), 32'd4);
    tick();

    // backpressure on JAL, target 0x210
    out_ready = 1'b0;
    drv(32'h44, 32'd0, 1'b0, 3'b000, 1'b0, 1'b1, 32'h10, 32'h200, 5'd5);
    tick();
    drv(32'd9, 32'd9, 1'b0, 3'b000, 1'b0, 1'b0, 32'd0, 32'd0, 5'd6);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_ex_op1", ex_op1, 32'h44);
      chk("bp_ex_addimm", ex_jump_addimm, 32'h200);
      chk("bp_redir", 32'(redirect_valid), 32'd0);
      chk("bp_ready", 32'(in_ready), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_redir", 32'(redirect_valid), 32'd1);
    chk("bp_release_pc", redirect_pc, 32'h210);
    chk("bp_release_ready", 32'(in_ready), 32'd0);
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      chk("bp_single_pulse", 32'(redirect_valid), 32'd0);
      tick();
    end

    // flush a stalled jump
    out_ready = 1'b0;
    drv(32'd0, 32'd0, 1'b0, 3'b000, 1'b0, 1'b1, 32'h4, 32'h300, 5'd8);
    tick();
    idle();
    #1 chk("fl_held", 32'(out_valid), 32'd1);
    flush = 1'b1; out_ready = 1'b1;
    #1;
    chk("fl_valid", 32'(out_valid), 32'd0);
    chk("fl_redir", 32'(redirect_valid), 32'd0);
    chk("fl_ready", 32'(in_ready), 32'd0);
    tick();
    flush = 1'b0;
    #1;
    chk("fl_after_valid", 32'(out_valid), 32'd0);
    chk("fl_after_redir", 32'(redirect_valid), 32'd0);
    chk("fl_after_ready", 32'(in_ready), 32'd1);

    // perf counters: reset, 3 ALU ops + 1 jump, then flush a held op
    rst = 1'b1;
    #2 rst = 1'b0;
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drv(32'(i), 32'd1, 1'b0, 3'b000, 1'b0, 1'b0, 32'd0, 32'd0, 5'd9);
      tick();
    end
    drv(32'd0, 32'd0, 1'b0, 3'b000, 1'b0, 1'b1, 32'h8, 32'h400, 5'd1);
    tick();
    idle();
    tick();
    tick();
    tick();
    out_ready = 1'b0;
    drv(32'd1, 32'd2, 1'b0, 3'b000, 1'b0, 1'b0, 32'd0, 32'd0, 5'd2);
    tick();
    idle();
    flush = 1'b1; out_ready = 1'b1;
    tick();
    flush = 1'b0;
    #1;
`ifdef R200EX_SEQ_PERF_EN
    chk("perf_retired", perf_retired, 32'd4);
    chk("perf_redirects", perf_redirects, 32'd1);
`else
    chk("perf_retired", perf_retired, 32'd0);
    chk("perf_redirects", perf_redirects, 32'd0);
`endif

    // asynchronous reset in the middle of SQUASH
    drv(32'h55, 32'd0, 1'b0, 3'b000, 1'b0, 1'b1, 32'h8, 32'h500, 5'd3);
    tick();
    drv(32'd7, 32'd7, 1'b0, 3'b000, 1'b0, 1'b0, 32'd0, 32'd0, 5'd4);
    #1 chk("ar_pre_redir", 32'(redirect_valid), 32'd1);
    tick();
    chk("ar_in_squash", 32'(out_valid), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("ar_valid", 32'(out_valid), 32'd0);
    chk("ar_redir", 32'(redirect_valid), 32'd0);
    chk("ar_ex_op1", ex_op1, 32'd0);
    chk("ar_ex_imm", ex_jump_imm, 32'd0);
    chk("ar_pc", redirect_pc, 32'd0);
    chk("ar_perf", perf_redirects, 32'd0);
    chk("ar_ready", 32'(in_ready), 32'd1);
    #1 rst = 1'b0;
    idle();
    tick();
    chk("ar_after_ready", 32'(in_ready), 32'd1);
    chk("ar_after_valid", 32'(out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
